// File: rtl/romram_arbiter.sv
// Two-master round-robin Wishbone arbiter for the monitor ROM/RAM slave,
// holding each grant for a whole cyc period and guarding the slave with a watchdog.
module romram_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m0_cyc,
    input  logic            m0_stb,
    input  logic            m0_we,
    input  logic [DW/8-1:0] m0_sel,
    input  logic [AW-1:0]   m0_adr,
    input  logic [DW-1:0]   m0_dat_o,
    output logic [DW-1:0]   m0_dat_i,
    output logic            m0_ack,
    output logic            m0_err,
    input  logic            m1_cyc,
    input  logic            m1_stb,
    input  logic            m1_we,
    input  logic [DW/8-1:0] m1_sel,
    input  logic [AW-1:0]   m1_adr,
    input  logic [DW-1:0]   m1_dat_o,
    output logic [DW-1:0]   m1_dat_i,
    output logic            m1_ack,
    output logic            m1_err,
    output logic            s_cyc,
    output logic            s_stb,
    output logic            s_we,
    output logic [DW/8-1:0] s_sel,
    output logic [AW-1:0]   s_adr,
    output logic [DW-1:0]   s_dat_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack,
    input  logic            s_err,
    output logic [1:0]      gnt
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_next;
    logic       last, last_next;
    logic [7:0] wd_count;
    logic       arb_en;
    logic       stb_raw;
    logic       wd_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            last  <= last_next;
        end
    end

    always_comb begin
        state_next = state;
        last_next  = last;
        arb_en     = (state == IDLE) || (state == GNT0 && !m0_cyc) || (state == GNT1 && !m1_cyc);
        if (arb_en) begin
            if (m0_cyc && m1_cyc) begin
                // On a tie the master that did not hold the bus last wins.
                state_next = last ? GNT0 : GNT1;
                last_next  = !last;
            end else if (m0_cyc) begin
                state_next = GNT0;
                last_next  = 1'b0;
            end else if (m1_cyc) begin
                state_next = GNT1;
                last_next  = 1'b1;
            end else begin
                state_next = IDLE;
            end
        end
    end

    assign gnt = {state == GNT1, state == GNT0};

    assign stb_raw = (m0_stb & gnt[0]) | (m1_stb & gnt[1]);
    assign wd_fire = (wd_count == WD_LAST) & stb_raw & ~s_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_count <= '0;
        end else if (!stb_raw || s_ack || s_err || wd_fire) begin
            wd_count <= '0;
        end else begin
            wd_count <= wd_count + 8'd1;
        end
    end

    always_comb begin
        s_cyc   = (m0_cyc & gnt[0]) | (m1_cyc & gnt[1]);
        s_stb   = stb_raw & ~wd_fire;
        s_we    = 1'b0;
        s_sel   = '0;
        s_adr   = '0;
        s_dat_o = '0;
        if (gnt[0]) begin
            s_we    = m0_we;
            s_sel   = m0_sel;
            s_adr   = m0_adr;
            s_dat_o = m0_dat_o;
        end else if (gnt[1]) begin
            s_we    = m1_we;
            s_sel   = m1_sel;
            s_adr   = m1_adr;
            s_dat_o = m1_dat_o;
        end
    end

    assign m0_dat_i = s_dat_i;
    assign m1_dat_i = s_dat_i;
    assign m0_ack   = s_ack & gnt[0];
    assign m1_ack   = s_ack & gnt[1];
    assign m0_err   = (s_err | wd_fire) & gnt[0];
    assign m1_err   = (s_err | wd_fire) & gnt[1];

endmodule

// File: doc/romram_arbiter.md
Name: romram_arbiter

Overview:
- Two-master Wishbone arbiter and sequencer in front of the on-chip monitor ROM/scratch-pad RAM slave at 0x40000000.
- Shares the single slave port between master 0 (instruction fetch) and master 1 (data/debug loader) using round-robin arbitration.
- Holds each grant for the master's whole cyc period.
- Adds a bus watchdog that returns err when the slave fails to ack.

Parameters:
- AW, 32, address width.
- DW, 32, data width; SEL width is DW/8.
- TIMEOUT, 16, cycles of unacknowledged s_stb before err is returned; legal range 2..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 cycle, strobe and write enable.
- m0_sel  in  DW/8  master 0 byte selects.
- m0_adr  in  AW  master 0 address.
- m0_dat_o  in  DW  master 0 write data.
- m0_dat_i  out  DW  read data to master 0.
- m0_ack, m0_err  out  1 each  master 0 terminations.
- m1_*: same set and widths as m0_*, for master 1.
- s_cyc, s_stb, s_we  out  1 each  to slave.
- s_sel  out  DW/8  to slave.
- s_adr  out  AW  to slave.
- s_dat_o  out  DW  write data to slave.
- s_dat_i  in  DW  read data from slave.
- s_ack, s_err  in  1 each  slave terminations.
- gnt  out  2  one-hot current grant; 00 = idle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, gnt=00, last=1 so master 0 wins the first tie, watchdog count=0.
  - All slave-side and master-side control outputs are 0.
  - Reset mid-transfer aborts the transfer immediately; no ack or err is emitted.
- States: IDLE, GNT0, GNT1. gnt is the registered state decode: GNT0 -> 01, GNT1 -> 10.
- Arbitration is evaluated in IDLE, and on the cycle the granted master's cyc is low while in GNTx.
  - Only one requester (mX_cyc=1): grant it.
  - Both requesting: grant the master not equal to last.
  - None requesting: go to IDLE.
- Switching:
  - A GNTx whose cyc drops can go directly to GNTy on the next edge; there is no dead cycle.
  - last updates to the new grantee on every grant.
- Latency: mX_cyc rising at edge n (bus idle) -> gnt valid after edge n+1 -> s_stb seen by the slave in cycle n+1.
- Grant hold:
  - While in GNTx with mX_cyc=1, the grant is never pre-empted, including across multiple stb/ack beats.
  - The other master's requests wait.
- Muxing (combinational from gnt):
  - s_cyc = mX_cyc & gntX; s_stb = mX_stb & gntX & ~wd_fire.
  - s_we, s_sel, s_adr and s_dat_o come from the granted master; all are 0 when gnt=00.
- Return path:
  - m0_dat_i = m1_dat_i = s_dat_i (broadcast).
  - mX_ack = s_ack & gntX.
  - mX_err = (s_err | wd_fire) & gntX.
  - A non-granted master never sees ack or err.
- Watchdog:
  - Count increments each cycle s_stb=1 and s_ack=0 and s_err=0.
  - Count clears on ack, on err, or when s_stb=0.
  - wd_fire = (count == TIMEOUT-1) & s_stb & ~s_ack.
  - wd_fire produces a one-cycle err to the granted master, suppresses s_stb that cycle, and clears count.
  - s_ack and wd_fire in the same cycle: ack wins, no err.
- Slave timing: the slave acks one cycle after stb and inserts one idle cycle between beats when stb is held. The arbiter needs no special case for this; the watchdog does not fire for this pattern.
- Both masters raising cyc on the same edge from reset: master 0 is granted.

Test Plan:
- Single read, m0 reads 0x40000010 (slave returns 0xDEADBEEF):
  - gnt=01 one cycle after cyc, s_stb for one cycle, m0_ack one cycle later with m0_dat_i=0xDEADBEEF.
  - m1_ack stays 0 throughout.
- Contention:
  - m0 and m1 assert cyc on the same cycle after reset -> gnt=01 first.
  - m1 is held with no ack until m0_cyc drops, then gnt=10 on the next edge with no IDLE cycle.
  - Repeating the simultaneous request grants 01 again (round-robin alternates).
- Locked burst:
  - m1 does 4 writes to 0x40010000..0x4001000C, sel=1111, holding cyc while m0_cyc=1 throughout.
  - gnt stays 10 for all 4 acks; s_adr and s_dat_o track m1.
  - m0 is granted only after m1_cyc falls.
- Watchdog, TIMEOUT=16, s_ack tied 0:
  - m0_err pulses exactly one cycle, 16 cycles after s_stb first rises.
  - s_stb is low in that cycle; count restarts if m0 keeps stb high.
- Ack beats timeout:
  - s_ack arrives in the same cycle count reaches 15 -> m0_ack=1, m0_err=0.
- Async reset mid-transfer:
  - rst_n low while gnt=10 -> gnt=00, s_stb=0 and s_cyc=0 without waiting for clk.
  - After release, the first simultaneous request goes to m0.
